// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage merged with the MEM/WB register: word load/store against an internal RAM
module mem_wb_stage #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_reg_write,
  input  logic [4:0]        in_dest,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [DATA_W-1:0] in_store_data,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_fault,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic {ACCEPT, LOAD_WAIT} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data;
  logic [4:0]        load_dest;
  logic              load_reg_write;

  logic [ADDR_W-1:0] idx;
  logic              misaligned;
  logic              fault;
  logic              accept;
  logic              do_load;
  logic              do_store;

  // Decode the EX/MEM fields; upper address bits are dropped so addresses alias.
  always_comb begin
    idx        = in_alu_out[ADDR_W+1:2];
    misaligned = (in_alu_out[1:0] != 2'b00);
    fault      = ((in_mem_read || in_mem_write) && misaligned) ||
                 (in_mem_read && in_mem_write);
    accept     = (state == ACCEPT) && in_valid;
    do_load    = accept && in_mem_read && !fault;
    do_store   = accept && in_mem_write && !fault;
    // Only the acceptance cycle of a load holds upstream; reset forces it low.
    stall      = do_load && !reset;
  end

  // Data RAM: write at the store edge, registered read at the load acceptance edge.
  always_ff @(posedge clock) begin
    if (do_store && !reset) begin
      mem[idx] <= in_store_data;
    end
    if (do_load) begin
      rd_data <= mem[idx];
    end
  end

  // Debug port reads the array directly so a store is visible right after its edge.
  assign dbg_data = mem[dbg_addr];

  // Pipeline FSM and registered write-back fields.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ACCEPT;
      wb_valid       <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_dest        <= 5'd0;
      wb_data        <= '0;
      wb_fault       <= 1'b0;
      load_dest      <= 5'd0;
      load_reg_write <= 1'b0;
    end else begin
      case (state)
        ACCEPT: begin
          if (!in_valid) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_fault     <= 1'b0;
          end else if (fault) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_fault     <= 1'b1;
            wb_dest      <= in_dest;
            wb_data      <= in_alu_out;
          end else if (in_mem_write) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_fault     <= 1'b0;
            wb_dest      <= in_dest;
            wb_data      <= in_alu_out;
          end else if (in_mem_read) begin
            // Nothing retires this edge; the load completes from LOAD_WAIT.
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_fault       <= 1'b0;
            load_dest      <= in_dest;
            load_reg_write <= in_reg_write;
            state          <= LOAD_WAIT;
          end else begin
            wb_valid     <= 1'b1;
            wb_reg_write <= in_reg_write;
            wb_fault     <= 1'b0;
            wb_dest      <= in_dest;
            wb_data      <= in_alu_out;
          end
        end
        LOAD_WAIT: begin
          wb_valid     <= 1'b1;
          wb_reg_write <= load_reg_write;
          wb_fault     <= 1'b0;
          wb_dest      <= load_dest;
          wb_data      <= rd_data;
          state        <= ACCEPT;
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage with a word-array reference model
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_mem_read = 1'b0;
  logic        in_mem_write = 1'b0;
  logic        in_reg_write = 1'b0;
  logic [4:0]  in_dest = 5'd0;
  logic [31:0] in_alu_out = 32'd0;
  logic [31:0] in_store_data = 32'd0;
  logic        stall;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb_fault;
  logic [5:0]  dbg_addr = 6'd0;
  logic [31:0] dbg_data;

  mem_wb_stage #(.ADDR_W(6), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_reg_write(in_reg_write), .in_dest(in_dest),
    .in_alu_out(in_alu_out), .in_store_data(in_store_data), .stall(stall),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest),
    .wb_data(wb_data), .wb_fault(wb_fault), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rw;
    logic [4:0]  dest;
    logic [31:0] data;
    logic        fault;
    logic        chk_dest;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] mm [64];
  bit          mm_ok = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented write-back is matched against the oldest expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (wb_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_wb_valid", 32'd1, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("wb_cycle", cyc, mon_e.cyc);
          chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, mon_e.rw});
          chk("wb_fault", {31'd0, wb_fault}, {31'd0, mon_e.fault});
          chk("wb_data", wb_data, mon_e.data);
          if (mon_e.chk_dest) chk("wb_dest", {27'd0, wb_dest}, {27'd0, mon_e.dest});
        end
      end
    end
  end

  // Drive one EX/MEM slot; a good load is held through its wait cycle like a stalled upstream.
  task automatic issue(input logic v, input logic r, input logic w, input logic rw,
                       input logic [4:0] d, input logic [31:0] a, input logic [31:0] sd,
                       input bit push);
    bit   flt;
    bit   ld;
    exp_t e;
    @(negedge clock);
    in_valid = v; in_mem_read = r; in_mem_write = w; in_reg_write = rw;
    in_dest = d; in_alu_out = a; in_store_data = sd;
    dbg_addr = 6'($urandom);
    #1;
    if (mm_ok) chk("dbg_data", dbg_data, mm[dbg_addr]);
    flt = ((r || w) && (a[1:0] != 2'b00)) || (r && w);
    ld  = v && r && !flt;
    chk("stall_accept", {31'd0, stall}, {31'd0, ld});
    if (v) begin
      e.fault    = flt;
      e.cyc      = cyc + (ld ? 2 : 1);
      e.chk_dest = !(w && !flt);
      e.dest     = d;
      if (flt) begin
        e.rw = 1'b0; e.data = a;
      end else if (w) begin
        e.rw = 1'b0; e.data = a; mm[a[7:2]] = sd;
      end else if (r) begin
        e.rw = rw; e.data = mm[a[7:2]];
      end else begin
        e.rw = rw; e.data = a;
      end
      if (push) sbq.push_back(e);
    end
    if (ld) begin
      @(negedge clock);
      #1;
      chk("stall_load_wait", {31'd0, stall}, 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_wb_reg_write"}, {31'd0, wb_reg_write}, 32'd0);
    chk({tag, "_wb_dest"}, {27'd0, wb_dest}, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_wb_fault"}, {31'd0, wb_fault}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    logic [31:0] a;
    #2;
    chk_all_zero("reset_init");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Fill every word so later loads have known contents.
    for (int i = 0; i < 64; i++) begin
      issue(1, 0, 1, 0, 5'($urandom), (32'($urandom) & 32'hFFFF_FF00) | (i << 2), $urandom, 1);
    end
    for (int i = 0; i < 64; i++) ;
    issue(0, 0, 0, 0, 0, 0, 0, 1);
    mm_ok = 1;

    // Store then immediately load the same word.
    issue(1, 0, 1, 0, 5'd0, 32'h10, 32'hDEADBEEF, 1);
    issue(1, 1, 0, 1, 5'd8, 32'h10, 32'h0, 1);
    @(negedge clock);
    in_valid = 0; dbg_addr = 6'd4;
    #1;
    chk("dbg_word4", dbg_data, 32'hDEADBEEF);

    // Aliasing above the RAM size.
    issue(1, 0, 1, 0, 5'd0, 32'h104, 32'h12345678, 1);
    issue(1, 1, 0, 1, 5'd3, 32'h004, 32'h0, 1);
    issue(0, 0, 0, 0, 0, 0, 0, 1);
    chk("alias_model", mm[1], 32'h12345678);

    // Faults: misaligned load, then read and write together.
    issue(1, 1, 0, 1, 5'd7, 32'h3, 32'h0, 1);
    issue(1, 1, 1, 1, 5'd9, 32'h20, 32'h55, 1);

    // ALU pass-through, bubble, back-to-back loads, store right after a load.
    issue(1, 0, 0, 1, 5'd5, 32'h7F, 32'h0, 1);
    issue(0, 0, 0, 1, 5'd6, 32'h99, 32'h0, 1);
    issue(1, 1, 0, 1, 5'd10, 32'h40, 32'h0, 1);
    issue(1, 1, 0, 0, 5'd11, 32'h44, 32'h0, 1);
    issue(1, 0, 1, 0, 5'd12, 32'h44, 32'hCAFEF00D, 1);
    issue(1, 1, 0, 1, 5'd13, 32'h44, 32'h0, 1);

    // Reset while the load is in LOAD_WAIT: the load must vanish.
    issue(1, 1, 0, 1, 5'd14, 32'h48, 32'h0, 0);
    #1;
    reset = 1'b1;
    #1;
    chk_all_zero("reset_mid_load");
    @(negedge clock);
    in_valid = 0;
    @(negedge clock);
    reset = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0, 1);
    issue(0, 0, 0, 0, 0, 0, 0, 1);
    issue(1, 0, 0, 1, 5'd15, 32'hABCD, 32'h0, 1);
    chk("store_survives_reset", mm[6'h11], 32'hCAFEF00D);

    // Randomized mix.
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      a = $urandom;
      case (k)
        0:       issue(0, 0, 0, 0, 5'($urandom), a, $urandom, 1);
        1, 2:    issue(1, 0, 0, 1'($urandom), 5'($urandom), a, $urandom, 1);
        3, 4:    issue(1, 0, 1, 1'($urandom), 5'($urandom), a & ~32'h3, $urandom, 1);
        5, 6, 7: issue(1, 1, 0, 1'($urandom), 5'($urandom), a & ~32'h3, $urandom, 1);
        8:       issue(1, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), a | 32'h1, $urandom, 1);
        default: issue(1, 1, 1, 1'($urandom), 5'($urandom), a & ~32'h3, $urandom, 1);
      endcase
    end

    issue(0, 0, 0, 0, 0, 0, 0, 1);
    issue(0, 0, 0, 0, 0, 0, 0, 1);
    issue(0, 0, 0, 0, 0, 0, 0, 1);
    chk("scoreboard_empty", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
